encoder8_3: RTL and testbench



---
 rtl/encoder8_3.sv | 64 ++++++
 tb/tb_encoder8_3.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder8_3.sv
// Registered 8-to-3 priority encoder with enable and a valid flag.
// Optional multi-hot error output is enabled by defining ENCODER8_3_ONEHOT_ERR_EN.
module encoder8_3 #(
   parameter bit MSB_PRIORITY = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i,
   input  logic       enb,
   output logic [2:0] y,
   output logic       valid
`ifdef ENCODER8_3_ONEHOT_ERR_EN
   ,
   output logic       err
`endif
);

   logic [2:0] idx;
   logic       any;

   // Later loop iterations override earlier ones, so the scan order sets which set bit wins.
   always_comb begin
      idx = 3'd0;
      any = |i;
      if (MSB_PRIORITY) begin
         for (int k = 0; k < 8; k++) begin
            if (i[k]) idx = 3'(k);
         end
      end else begin
         for (int k = 7; k >= 0; k--) begin
            if (i[k]) idx = 3'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y     <= 3'd0;
         valid <= 1'b0;
      end else if (enb && any) begin
         y     <= idx;
         valid <= 1'b1;
      end else begin
         y     <= 3'd0;
         valid <= 1'b0;
      end
   end

`ifdef ENCODER8_3_ONEHOT_ERR_EN
   logic multi;

   // Clearing the lowest set bit leaves something behind only when two or more bits were set.
   assign multi = |(i & (i - 8'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err <= 1'b0;
      end else begin
         err <= enb && multi;
      end
   end
`endif

endmodule

// File: tb/tb_encoder8_3.sv
// Self-checking bench for encoder8_3: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_encoder8_3;

   localparam bit MSB_PRIORITY = 1'b1;

   logic       clk;
   logic       rst_n;
   logic [7:0] i;
   logic       enb;
   logic [2:0] y;
   logic       valid;
`ifdef ENCODER8_3_ONEHOT_ERR_EN
   logic       err;
`endif

   int checks;
   int errors;

   encoder8_3 #(.MSB_PRIORITY(MSB_PRIORITY)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .i     (i),
      .enb   (enb),
      .y     (y),
      .valid (valid)
`ifdef ENCODER8_3_ONEHOT_ERR_EN
      ,
      .err   (err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: index found by repeated halving (log2), lowest bit isolated by v & -v.
   task automatic ref_model(input logic [7:0] v, input logic e,
                            output logic [2:0] ey, output logic ev, output logic ee);
      int n;
      int idx;
      int ones;
      ey = 3'd0;
      ev = 1'b0;
      ee = 1'b0;
      if (e && v != 8'd0) begin
         n = MSB_PRIORITY ? int'(v) : (int'(v) & -int'(v));
         idx = 0;
         while (n > 1) begin
            n = n / 2;
            idx++;
         end
         ey = 3'(idx);
         ev = 1'b1;
         n = int'(v);
         ones = 0;
         while (n > 0) begin
            ones += n % 2;
            n = n / 2;
         end
         ee = (ones > 1);
      end
   endtask

   // Drive inputs just after an edge, then sample one cycle later away from the edge.
   task automatic applyStimulus(input logic [7:0] v, input logic e);
      i   = v;
      enb = e;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [2:0] ey;
      logic ev, ee;
      rst_n = 1'b0;
      i = 8'hFF;
      enb = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({y, valid} !== {3'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_hold: y=%b valid=%b, required y=000 valid=0", y, valid);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ref_model(8'hFF, 1'b1, ey, ev, ee);
      checks++;
      if ({y, valid} !== {ey, ev}) begin
         errors++;
         $display("[TB] FAIL reset_release: y=%b valid=%b, required y=%b valid=%b", y, valid, ey, ev);
      end
   endtask

   task automatic test_onehot_sweep(input logic e, input string tag);
      logic [2:0] ey;
      logic ev, ee;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'(1 << k), e);
         ref_model(8'(1 << k), e, ey, ev, ee);
         checks++;
         if ({y, valid} !== {ey, ev}) begin
            errors++;
            $display("[TB] FAIL %s bit%0d: y=%b valid=%b, required y=%b valid=%b",
                     tag, k, y, valid, ey, ev);
         end
      end
   endtask

   task automatic test_reenable();
      applyStimulus(8'h20, 1'b1);
      checks++;
      if ({y, valid} !== {3'b101, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reenable: y=%b valid=%b, required y=101 valid=1", y, valid);
      end
   endtask

   task automatic test_zero_priority();
      logic [2:0] ey;
      logic ev, ee;
      applyStimulus(8'h00, 1'b1);
      checks++;
      if ({y, valid} !== {3'd0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL zero_input: y=%b valid=%b, required y=000 valid=0", y, valid);
      end
      applyStimulus(8'b0101_0010, 1'b1);
      ey = MSB_PRIORITY ? 3'b110 : 3'b001;
      checks++;
      if ({y, valid} !== {ey, 1'b1}) begin
         errors++;
         $display("[TB] FAIL priority: y=%b valid=%b, required y=%b valid=1", y, valid, ey);
      end
`ifdef ENCODER8_3_ONEHOT_ERR_EN
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL err_multihot: err=%b, required 1", err);
      end
`endif
   endtask

   task automatic test_async_reset();
      logic [2:0] ey;
      logic ev, ee;
      applyStimulus(8'h08, 1'b1);
      checks++;
      if ({y, valid} !== {3'b011, 1'b1}) begin
         errors++;
         $display("[TB] FAIL pre_async: y=%b valid=%b, required y=011 valid=1", y, valid);
      end
      #2;
      i = 8'h40;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({y, valid} !== {3'd0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL async_clear: y=%b valid=%b, required y=000 valid=0", y, valid);
      end
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ref_model(8'h40, 1'b1, ey, ev, ee);
      checks++;
      if ({y, valid} !== {ey, ev}) begin
         errors++;
         $display("[TB] FAIL async_resume: y=%b valid=%b, required y=%b valid=%b", y, valid, ey, ev);
      end
   endtask

   task automatic test_random();
      logic [2:0] ey;
      logic ev, ee;
      logic [7:0] v;
      logic e;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(3))
            0:       v = 8'(1 << $urandom_range(7));
            1:       v = 8'h00;
            default: v = 8'($urandom);
         endcase
         e = ($urandom_range(3) != 0);
         applyStimulus(v, e);
         ref_model(v, e, ey, ev, ee);
         checks++;
         if ({y, valid} !== {ey, ev}) begin
            errors++;
            $display("[TB] FAIL random i=%h enb=%b: y=%b valid=%b, required y=%b valid=%b",
                     v, e, y, valid, ey, ev);
         end
`ifdef ENCODER8_3_ONEHOT_ERR_EN
         checks++;
         if (err !== ee) begin
            errors++;
            $display("[TB] FAIL random_err i=%h enb=%b: err=%b, required %b", v, e, err, ee);
         end
`endif
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      i = 8'h00;
      enb = 1'b0;
      test_reset();
      test_onehot_sweep(1'b1, "onehot_sweep");
      test_onehot_sweep(1'b0, "disable_sweep");
      test_reenable();
      test_zero_priority();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
